// File: rtl/alu_pkg.sv
// Shared opcode map, control-state encoding and opcode classification
// for the iterative ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLTU  = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRA   = 4'b1001;
  localparam logic [3:0] ALU_SLT   = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1011;
  localparam logic [3:0] ALU_MULHU = 4'b1100;
  localparam logic [3:0] ALU_DIVU  = 4'b1101;
  localparam logic [3:0] ALU_REMU  = 4'b1110;
  localparam logic [3:0] ALU_RSVD  = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_MULHU) ||
           (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/mul_div_iter.sv
// One-bit-per-cycle shift-add multiplier / restoring divider.
// lo/hi present the value after the current step, so the caller can capture on done.
module mul_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_r;
  logic             mode_r;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [WIDTH-1:0] opnd_r;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   trial_s;
  logic [WIDTH-1:0] hi_nxt_s;
  logic [WIDTH-1:0] lo_nxt_s;

  // Next step: mul shifts {carry,hi,lo} right; div shifts {hi,lo} left and trial-subtracts.
  always_comb begin
    sum_s    = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
    trial_s  = {hi_r, lo_r[WIDTH-1]} - {1'b0, opnd_r};
    hi_nxt_s = hi_r;
    lo_nxt_s = lo_r;
    if (mode_r) begin
      if (!trial_s[WIDTH]) begin
        hi_nxt_s = trial_s[WIDTH-1:0];
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt_s = {hi_r[WIDTH-2:0], lo_r[WIDTH-1]};
        lo_nxt_s = {lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nxt_s = sum_s[WIDTH:1];
      lo_nxt_s = {sum_s[0], lo_r[WIDTH-1:1]};
    end
  end

  assign done = busy_r && (cnt_r == {CW{1'b0}});
  assign lo   = lo_nxt_s;
  assign hi   = hi_nxt_s;

  // Operand load on start, then one step per cycle for WIDTH cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
      mode_r <= 1'b0;
      cnt_r  <= {CW{1'b0}};
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= {WIDTH{1'b0}};
      opnd_r <= {WIDTH{1'b0}};
    end else if (start) begin
      busy_r <= 1'b1;
      mode_r <= mode;
      cnt_r  <= CW'(WIDTH - 1);
      hi_r   <= {WIDTH{1'b0}};
      lo_r   <= mode ? a : b;
      opnd_r <= mode ? b : a;
    end else if (busy_r) begin
      hi_r  <= hi_nxt_s;
      lo_r  <= lo_nxt_s;
      cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
      if (cnt_r == {CW{1'b0}}) begin
        busy_r <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/iter_alu.sv
// Handshaked ALU: single-cycle logic/arith/shift/compare ops plus iterative
// mul/mulhu/divu/remu, with a registered result and zero flag.
module iter_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] res_r;
  logic             zero_r;
  logic             in_ready_r;
  logic             out_valid_r;

  logic             accept_s;
  logic             div_op_s;
  logic             div_zero_s;
  logic             md_start_s;
  logic             md_done_s;
  logic [WIDTH-1:0] md_lo_s;
  logic [WIDTH-1:0] md_hi_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH-1:0] simple_s;
  logic [WIDTH-1:0] res_nxt_s;

  assign accept_s   = in_valid && in_ready_r;
  assign div_op_s   = (op == ALU_DIVU) || (op == ALU_REMU);
  assign div_zero_s = div_op_s && (b == {WIDTH{1'b0}});
  assign md_start_s = accept_s && is_multicycle(op) && !div_zero_s;
  assign sh_s       = b[SHW-1:0];

  mul_div_iter #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .start (md_start_s),
    .mode  (div_op_s),
    .a     (a),
    .b     (b),
    .done  (md_done_s),
    .lo    (md_lo_s),
    .hi    (md_hi_s)
  );

  // Single-cycle operations; multicycle and reserved codes fall to zero.
  always_comb begin
    simple_s = {WIDTH{1'b0}};
    case (op)
      ALU_AND:  simple_s = a & b;
      ALU_OR:   simple_s = a | b;
      ALU_ADD:  simple_s = a + b;
      ALU_XOR:  simple_s = a ^ b;
      ALU_NOR:  simple_s = ~(a | b);
      ALU_SRL:  simple_s = a >> sh_s;
      ALU_SUB:  simple_s = a - b;
      ALU_SLTU: simple_s = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:  simple_s = a << sh_s;
      ALU_SRA:  simple_s = $unsigned($signed(a) >>> sh_s);
      ALU_SLT:  simple_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default:  simple_s = {WIDTH{1'b0}};
    endcase
  end

  // Value to be registered into res when a result completes.
  always_comb begin
    res_nxt_s = res_r;
    case (state_r)
      IDLE: begin
        if (div_zero_s) begin
          res_nxt_s = (op == ALU_DIVU) ? {WIDTH{1'b1}} : a;
        end else begin
          res_nxt_s = simple_s;
        end
      end
      BUSY: begin
        if ((op_r == ALU_MUL) || (op_r == ALU_DIVU)) begin
          res_nxt_s = md_lo_s;
        end else begin
          res_nxt_s = md_hi_s;
        end
      end
      default: res_nxt_s = res_r;
    endcase
  end

  // Control FSM with registered handshake outputs and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      op_r        <= ALU_AND;
      res_r       <= {WIDTH{1'b0}};
      zero_r      <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            op_r       <= op;
            in_ready_r <= 1'b0;
            if (md_start_s) begin
              state_r <= BUSY;
            end else begin
              state_r     <= DONE;
              res_r       <= res_nxt_s;
              zero_r      <= (res_nxt_s == {WIDTH{1'b0}});
              out_valid_r <= 1'b1;
            end
          end
        end
        BUSY: begin
          if (md_done_s) begin
            state_r     <= DONE;
            res_r       <= res_nxt_s;
            zero_r      <= (res_nxt_s == {WIDTH{1'b0}});
            out_valid_r <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r     <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign res       = res_r;
  assign zero      = zero_r;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu at WIDTH=32 and WIDTH=8; sel picks the active DUT.
module tb_iter_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        sel;

  logic        ir32, ov32, z32, ir8, ov8, z8;
  logic [31:0] res32;
  logic [7:0]  res8;
  logic        cur_ir, cur_ov, cur_z;
  logic [31:0] cur_res;

  always #5 clk = ~clk;

  iter_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && !sel), .in_ready(ir32),
    .op(op), .a(a), .b(b), .out_valid(ov32), .out_ready(out_ready),
    .res(res32), .zero(z32)
  );

  iter_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && sel), .in_ready(ir8),
    .op(op), .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .out_ready(out_ready),
    .res(res8), .zero(z8)
  );

  assign cur_ir  = sel ? ir8 : ir32;
  assign cur_ov  = sel ? ov8 : ov32;
  assign cur_z   = sel ? z8 : z32;
  assign cur_res = sel ? {24'd0, res8} : res32;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (sel=%0d cyc=%0d)", name, got, exp, sel, cyc);
    end
  endtask

  // Reference behaviour from the opcode table, in plain 64-bit arithmetic.
  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] x32,
                                        input logic [31:0] y32, input int w);
    longint unsigned m, x, y, r;
    longint sx, sy;
    int sh;
    m  = (64'd1 << w) - 64'd1;
    x  = {32'd0, x32} & m;
    y  = {32'd0, y32} & m;
    sh = int'(y % 64'(w));
    sx = (x >= (64'd1 << (w - 1))) ? longint'(x) - longint'(64'd1 << w) : longint'(x);
    sy = (y >= (64'd1 << (w - 1))) ? longint'(y) - longint'(64'd1 << w) : longint'(y);
    case (o)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd2:  r = x + y;
      4'd3:  r = x ^ y;
      4'd4:  r = ~(x | y);
      4'd5:  r = x >> sh;
      4'd6:  r = x - y;
      4'd7:  r = (x < y) ? 64'd1 : 64'd0;
      4'd8:  r = x << sh;
      4'd9:  r = sx >>> sh;
      4'd10: r = (sx < sy) ? 64'd1 : 64'd0;
      4'd11: r = x * y;
      4'd12: r = (x * y) >> w;
      4'd13: r = (y == 64'd0) ? m : x / y;
      4'd14: r = (y == 64'd0) ? x : x % y;
      default: r = 64'd0;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int   w;
    int   n;
    exp_t e;
    logic [31:0] ym;
    w  = sel ? 8 : 32;
    n  = 0;
    ym = sel ? (y & 32'h0000_00FF) : y;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!cur_ir && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cur_ir) begin
      check("accept_timeout", {31'd0, cur_ir}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    e.res = model(o, x, y, w);
    e.lat = (o >= 4'd11 && o <= 4'd14 && !(o >= 4'd13 && ym == 32'd0)) ? w + 1 : 1;
    e.acc = cyc + 1;
    q.push_back(e);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((q.size() != 0 || !cur_ir) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", q.size(), 32'd0);
  endtask

  // Monitor: latency/value on first valid cycle, stability while held, pop on handshake.
  initial begin
    logic seen;
    seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        seen = 1'b0;
      end else if (cur_ov) begin
        if (q.size() == 0) begin
          check("spurious_out_valid", {31'd0, cur_ov}, 32'd0);
        end else begin
          if (!seen) begin
            check("latency", cyc - q[0].acc + 1, q[0].lat);
            check("res", cur_res, q[0].res);
            check("zero", {31'd0, cur_z}, {31'd0, (q[0].res == 32'd0)});
            seen = 1'b1;
          end else begin
            check("res_stable", cur_res, q[0].res);
          end
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL global_timeout: got cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0;
    op = 4'd0; a = 32'd0; b = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'd0, cur_ir}, 32'd1);
    check("rst_out_valid", {31'd0, cur_ov}, 32'd0);
    check("rst_res", cur_res, 32'd0);
    check("rst_zero", {31'd0, cur_z}, 32'd0);
    rst_n = 1'b1;

    for (int s = 0; s < 2; s++) begin
      @(posedge clk);
      #1 sel = s[0];
      w = s[0] ? 8 : 32;
      issue(4'b0110, 32'd5, 32'd5);
      issue(4'b1001, 32'h8000_0000, 32'h24);
      issue(4'b1010, 32'hFFFF_FFFF, 32'd1);
      issue(4'b1011, 32'hFFFF_FFFF, 32'd2);
      issue(4'b1100, 32'hFFFF_FFFF, 32'd2);
      issue(4'b1101, 32'd100, 32'd7);
      issue(4'b1110, 32'd100, 32'd7);
      issue(4'b1101, 32'd100, 32'd0);
      issue(4'b1110, 32'd100, 32'd0);
      issue(4'b1111, 32'h1234_5678, 32'd9);
      for (int i = 0; i < 40; i++) begin
        logic [31:0] rb;
        rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
        issue(4'($urandom_range(0, 15)), $urandom, rb);
      end
      wait_done();

      // Backpressure with a held request queued behind the stalled result.
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue(4'b0010, 32'd3, 32'd4);
      fork
        issue(4'b0011, 32'h00F0_F00F, 32'h0F0F_0FF0);
      join_none
      repeat (10) begin
        @(negedge clk);
        check("bp_in_ready_low", {31'd0, cur_ir}, 32'd0);
        check("bp_out_valid_high", {31'd0, cur_ov}, 32'd1);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("bp_in_ready_after_take", {31'd0, cur_ir}, 32'd1);
      wait fork;
      wait_done();

      // Reset while the iterative unit is busy: no result may appear.
      issue(4'b1011, $urandom, $urandom);
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b0;
      q.delete();
      @(negedge clk);
      check("midrst_in_ready", {31'd0, cur_ir}, 32'd1);
      check("midrst_out_valid", {31'd0, cur_ov}, 32'd0);
      check("midrst_res", cur_res, 32'd0);
      check("midrst_zero", {31'd0, cur_z}, 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (w + 5) begin
        @(negedge clk);
        check("midrst_no_valid", {31'd0, cur_ov}, 32'd0);
      end
      issue(4'b0001, 32'h0000_00A0, 32'h0000_000B);
      wait_done();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
